// File: rtl/bus_controller.sv
// Three-CPU snooping bus controller: round-robin grant, broadcast, snoop/write-back, respond.
// Outputs are registered from the current state, so each phase is seen on the ports one cycle later.
module bus_controller (
   input  logic        clock,
   input  logic        resetn,
   input  logic [17:0] cpu_bus_out,
   input  logic [2:0]  cpu_wb,
   input  logic [11:0] cpu_wb_data,
   output logic [5:0]  bus_in,
   output logic [1:0]  bus_src,
   output logic [3:0]  fill_data,
   output logic [2:0]  fill_valid,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BCAST = 3'd1,
      S_SNOOP = 3'd2,
      S_WMEM  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  last_q, last_d;
   logic [1:0]  src_q, src_d;
   logic [1:0]  msg_q, msg_d;
   logic [2:0]  addr_q, addr_d;
   logic [3:0]  resp_q, resp_d;
   logic [3:0]  mem_q [8];
   logic [5:0]  bus_in_q, bus_in_d;
   logic [3:0]  fill_data_q, fill_data_d;
   logic [2:0]  fill_valid_q, fill_valid_d;

   logic [5:0]  req [3];
   logic [3:0]  wbd [3];
   logic [2:0]  vld;
   logic        gnt_ok;
   logic [1:0]  gnt, cand;
   logic        hit;
   logic [3:0]  hit_data;
   logic        mem_we;
   logic [3:0]  mem_wdata;

   function automatic logic [1:0] rr_idx(input logic [1:0] base, input logic [1:0] step);
      logic [2:0] s;
      s = {1'b0, base} + {1'b0, step};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         req[i] = cpu_bus_out[6*i +: 6];
         wbd[i] = cpu_wb_data[4*i +: 4];
         // The CPU seeing its fill this cycle drops valid at the coming edge; never re-grant it.
         vld[i] = cpu_bus_out[6*i + 5] & ~fill_valid_q[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      src_d       = src_q;
      msg_d       = msg_q;
      addr_d      = addr_q;
      resp_d      = resp_q;
      mem_we      = 1'b0;
      mem_wdata   = 4'd0;
      gnt_ok      = 1'b0;
      gnt         = 2'd0;
      cand        = 2'd0;
      hit         = 1'b0;
      hit_data    = 4'd0;

      for (int k = 1; k <= 3; k++) begin
         cand = rr_idx(last_q, 2'(k));
         if (!gnt_ok && vld[cand]) begin
            gnt_ok = 1'b1;
            gnt    = cand;
         end
      end

      for (int i = 0; i < 3; i++) begin
         if (!hit && cpu_wb[i] && (2'(i) != src_q)) begin
            hit      = 1'b1;
            hit_data = wbd[i];
         end
      end

      case (state_q)
         S_IDLE: begin
            if (gnt_ok) begin
               src_d   = gnt;
               last_d  = gnt;
               msg_d   = req[gnt][4:3];
               addr_d  = req[gnt][2:0];
               resp_d  = 4'd0;
               state_d = (req[gnt][4:3] == 2'b00) ? S_WMEM : S_BCAST;
            end
         end
         S_BCAST: state_d = (msg_q == 2'b11) ? S_RESP : S_SNOOP;
         S_SNOOP: begin
            if (hit) begin
               mem_we    = 1'b1;
               mem_wdata = hit_data;
               resp_d    = hit_data;
            end else begin
               resp_d    = mem_q[addr_q];
            end
            state_d = S_RESP;
         end
         S_WMEM: begin
            mem_we    = 1'b1;
            mem_wdata = wbd[src_q];
            resp_d    = 4'd0;
            state_d   = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      bus_in_d     = (state_q == S_BCAST) ? {1'b1, msg_q, addr_q} : 6'd0;
      fill_valid_d = (state_q == S_RESP) ? (3'b001 << src_q) : 3'd0;
      fill_data_d  = (state_q == S_RESP) ? resp_q : 4'd0;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         last_q       <= 2'd2;
         src_q        <= 2'd0;
         msg_q        <= 2'd0;
         addr_q       <= 3'd0;
         resp_q       <= 4'd0;
         bus_in_q     <= 6'd0;
         fill_data_q  <= 4'd0;
         fill_valid_q <= 3'd0;
         for (int i = 0; i < 8; i++) mem_q[i] <= 4'(i);
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         src_q        <= src_d;
         msg_q        <= msg_d;
         addr_q       <= addr_d;
         resp_q       <= resp_d;
         bus_in_q     <= bus_in_d;
         fill_data_q  <= fill_data_d;
         fill_valid_q <= fill_valid_d;
         if (mem_we) mem_q[addr_q] <= mem_wdata;
      end
   end

   assign bus_in     = bus_in_q;
   assign bus_src    = src_q;
   assign fill_data  = fill_data_q;
   assign fill_valid = fill_valid_q;
   assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed scenarios plus randomized traffic against a
// transaction-level timing model (grant edge, fixed latencies, memory array).
module tb_bus_controller;

   logic        clock = 1'b0;
   logic        resetn = 1'b1;
   logic [17:0] cpu_bus_out = '0;
   logic [2:0]  cpu_wb = '0;
   logic [11:0] cpu_wb_data = '0;
   logic [5:0]  bus_in;
   logic [1:0]  bus_src;
   logic [3:0]  fill_data;
   logic [2:0]  fill_valid;
   logic        busy;

   bus_controller dut (
      .clock       (clock),
      .resetn      (resetn),
      .cpu_bus_out (cpu_bus_out),
      .cpu_wb      (cpu_wb),
      .cpu_wb_data (cpu_wb_data),
      .bus_in      (bus_in),
      .bus_src     (bus_src),
      .fill_data   (fill_data),
      .fill_valid  (fill_valid),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   int n_chk = 0;
   int n_fail = 0;

   // Model: one transaction at a time, described by its grant edge and total latency.
   logic [3:0] m_mem [8];
   int         m_e, m_t0, m_lat;
   bit         m_act;
   logic [1:0] m_g, m_src, m_last, m_msg;
   logic [2:0] m_addr;
   logic [3:0] m_resp;
   logic [2:0] last_fv;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] wbd(input int i);
      return cpu_wb_data[4*i +: 4];
   endfunction

   task automatic model_reset();
      m_e = 0; m_t0 = 0; m_lat = 0; m_act = 0;
      m_g = 0; m_src = 0; m_last = 2; m_msg = 0; m_addr = 0; m_resp = 0;
      last_fv = 0;
      for (int i = 0; i < 8; i++) m_mem[i] = 4'(i);
   endtask

   task automatic model_step();
      bit done;
      int w;
      logic [5:0] r;
      m_e++;
      if (m_act && m_msg == 2'b00 && m_e == m_t0 + 1) m_mem[m_addr] = wbd(int'(m_g));
      if (m_act && (m_msg == 2'b01 || m_msg == 2'b10) && m_e == m_t0 + 2) begin
         w = -1;
         for (int j = 0; j < 3; j++) if (w < 0 && j != int'(m_g) && cpu_wb[j]) w = j;
         if (w >= 0) begin
            m_mem[m_addr] = wbd(w);
            m_resp = wbd(w);
         end else begin
            m_resp = m_mem[m_addr];
         end
      end
      if (!m_act || m_e > m_t0 + m_lat) begin
         done = 0;
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (int'(m_last) + k) % 3;
            if (!done && cpu_bus_out[6*c + 5] &&
                !(m_act && m_e == m_t0 + m_lat + 1 && c == int'(m_g))) begin
               done   = 1;
               r      = cpu_bus_out[6*c +: 6];
               m_act  = 1;
               m_t0   = m_e;
               m_g    = 2'(c);
               m_src  = 2'(c);
               m_last = 2'(c);
               m_msg  = r[4:3];
               m_addr = r[2:0];
               m_lat  = (r[4:3] == 2'b01 || r[4:3] == 2'b10) ? 3 : 2;
               m_resp = 0;
            end
         end
      end
   endtask

   task automatic compare_all();
      logic [5:0] eb;
      logic [2:0] ef;
      logic [3:0] ed;
      eb = (m_act && m_msg != 2'b00 && m_e == m_t0 + 1) ? {1'b1, m_msg, m_addr} : 6'd0;
      ef = (m_act && m_e == m_t0 + m_lat) ? (3'b001 << m_g) : 3'd0;
      ed = (ef != 0) ? m_resp : 4'd0;
      check("bus_in", 32'(bus_in), 32'(eb));
      check("bus_src", 32'(bus_src), 32'(m_src));
      check("fill_valid", 32'(fill_valid), 32'(ef));
      check("fill_data", 32'(fill_data), 32'(ed));
      check("busy", 32'(busy), 32'(m_act && m_e < m_t0 + m_lat));
   endtask

   // mode 0: hold; 1: random new requests and snoop flags; 2: re-request right after a drop.
   task automatic tick(input int mode);
      @(posedge clock);
      if (resetn) model_step();
      #1;
      for (int i = 0; i < 3; i++) if (last_fv[i]) cpu_bus_out[6*i + 5] = 1'b0;
      if (mode == 1) begin
         for (int i = 0; i < 3; i++)
            if (!cpu_bus_out[6*i + 5] && !last_fv[i] && $urandom_range(0, 3) == 0)
               cpu_bus_out[6*i +: 6] = {1'b1, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7))};
         cpu_wb      = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
         cpu_wb_data = 12'($urandom);
      end else if (mode == 2) begin
         for (int i = 0; i < 3; i++)
            if (!cpu_bus_out[6*i + 5] && !last_fv[i]) cpu_bus_out[6*i + 5] = 1'b1;
      end
      @(negedge clock);
      compare_all();
      last_fv = fill_valid;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      model_reset();
      #1;
      check("rst bus_in", 32'(bus_in), 0);
      check("rst bus_src", 32'(bus_src), 0);
      check("rst fill_valid", 32'(fill_valid), 0);
      check("rst fill_data", 32'(fill_data), 0);
      check("rst busy", 32'(busy), 0);
      repeat (2) tick(0);
      resetn = 1'b1;
   endtask

   task automatic wait_fill(input int maxc, output logic [2:0] fv, output logic [3:0] fd);
      fv = 0;
      fd = 0;
      for (int k = 0; k < maxc && fv == 0; k++) begin
         tick(0);
         if (fill_valid != 0) begin
            fv = fill_valid;
            fd = fill_data;
         end
      end
   endtask

   logic [2:0] fv;
   logic [3:0] fd;
   logic [2:0] order [4];
   int         n_ord;

   initial begin
      #2;
      do_reset();

      // Read miss, no snoop: CPU1 reads address 5.
      cpu_bus_out[11:6] = 6'b101101;
      tick(0);
      check("rm bus_src", 32'(bus_src), 1);
      check("rm busy", 32'(busy), 1);
      tick(0);
      check("rm bus_in", 32'(bus_in), 32'h2D);
      tick(0);
      tick(0);
      check("rm fill_valid", 32'(fill_valid), 3'b010);
      check("rm fill_data", 32'(fill_data), 4'h5);
      tick(0);

      // Write miss by CPU0 at address 3, CPU2 supplies 4'hA in SNOOP.
      cpu_bus_out[5:0] = 6'b110011;
      tick(0);
      check("wm bus_src", 32'(bus_src), 0);
      cpu_wb = 3'b100;
      cpu_wb_data[11:8] = 4'hA;
      tick(0);
      check("wm bus_in", 32'(bus_in), 32'h33);
      tick(0);
      cpu_wb = 3'b000;
      tick(0);
      check("wm fill_valid", 32'(fill_valid), 3'b001);
      check("wm fill_data", 32'(fill_data), 4'hA);
      cpu_bus_out[11:6] = 6'b101011;
      wait_fill(10, fv, fd);
      check("rd3 fill_valid", 32'(fv), 3'b010);
      check("rd3 fill_data", 32'(fd), 4'hA);

      // Invalidate from CPU2.
      cpu_bus_out[17:12] = 6'b111000;
      tick(0);
      check("inv bus_src", 32'(bus_src), 2);
      tick(0);
      check("inv bus_in", 32'(bus_in), 32'h38);
      tick(0);
      check("inv bus_in once", 32'(bus_in), 0);
      check("inv fill_valid", 32'(fill_valid), 3'b100);
      check("inv fill_data", 32'(fill_data), 0);

      // Eviction write-back: CPU1 writes 4'h9 to address 6, then CPU0 reads it back.
      cpu_bus_out[11:6] = 6'b100110;
      cpu_wb_data[7:4]  = 4'h9;
      tick(0);
      check("wb bus_src", 32'(bus_src), 1);
      check("wb bus_in", 32'(bus_in), 0);
      tick(0);
      check("wb no bcast", 32'(bus_in), 0);
      tick(0);
      check("wb fill_valid", 32'(fill_valid), 3'b010);
      check("wb fill_data", 32'(fill_data), 0);
      cpu_wb_data = '0;
      cpu_bus_out[5:0] = 6'b101110;
      wait_fill(10, fv, fd);
      check("rd6 fill_valid", 32'(fv), 3'b001);
      check("rd6 fill_data", 32'(fd), 4'h9);
      tick(0);

      // Round-robin with all three CPUs requesting continuously.
      cpu_bus_out = '0;
      do_reset();
      cpu_bus_out = {6'b101010, 6'b101001, 6'b101000};
      n_ord = 0;
      for (int k = 0; k < 40 && n_ord < 4; k++) begin
         tick(2);
         if (fill_valid != 0) begin
            order[n_ord] = fill_valid;
            n_ord++;
         end
      end
      check("rr count", 32'(n_ord), 4);
      check("rr grant0", 32'(order[0]), 3'b001);
      check("rr grant1", 32'(order[1]), 3'b010);
      check("rr grant2", 32'(order[2]), 3'b100);
      check("rr grant3", 32'(order[3]), 3'b001);
      cpu_bus_out = '0;
      repeat (6) tick(0);

      // Reset during SNOOP of a CPU1 write miss while CPU2 offers a write-back.
      do_reset();
      cpu_bus_out[11:6] = 6'b110100;
      cpu_wb = 3'b100;
      cpu_wb_data[11:8] = 4'hF;
      tick(0);
      check("abort grant", 32'(bus_src), 1);
      tick(0);
      check("abort bus_in", 32'(bus_in), 32'h34);
      #2;
      do_reset();
      cpu_wb = 3'b000;
      cpu_bus_out[5:0] = 6'b101100;
      tick(0);
      check("post-rst grant", 32'(bus_src), 0);
      wait_fill(10, fv, fd);
      check("post-rst fill_valid", 32'(fv), 3'b001);
      check("post-rst mem4", 32'(fd), 4'h4);
      wait_fill(10, fv, fd);
      check("cpu1 retry fill", 32'(fv), 3'b010);
      check("cpu1 retry data", 32'(fd), 4'h4);
      tick(0);

      // Randomized traffic against the model.
      cpu_bus_out = '0;
      do_reset();
      repeat (3000) tick(1);
      cpu_wb = '0;
      repeat (30) tick(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_controller.md
BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port clock, input, 1 bit: rising-edge system clock.
REQ-003 Port resetn, input, 1 bit: asynchronous active-low reset.
REQ-004 Port cpu_bus_out, input, 18 bits: three 6-bit requests, CPUn at [6n+5:6n].
- Request format: [5] valid; [4:3] msg (00 write-back, 01 read miss, 10 write miss, 11 invalidate); [2:0] address.
REQ-005 Port cpu_wb, input, 3 bits: CPUn snoop write-back flag.
REQ-006 Port cpu_wb_data, input, 12 bits: CPUn 4-bit line data at [4n+3:4n].
REQ-007 Port bus_in, output, 6 bits: broadcast message in the request format.
REQ-008 Port bus_src, output, 2 bits: index of the granted CPU.
REQ-009 Port fill_data, output, 4 bits: response data.
REQ-010 Port fill_valid, output, 3 bits: one-hot completion strobe to the granted CPU.
REQ-011 Port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-012 The block SHALL contain an 8 x 4-bit main memory; entry i resets to {1'b0,i}.
REQ-013 The FSM SHALL have five states: IDLE, BROADCAST, SNOOP, WRITEMEM, RESPOND.
REQ-014 In IDLE, at a clock edge with at least one valid request, the block SHALL grant one CPU by round-robin.
- Priority order: last_grant+1, last_grant+2, last_grant (mod 3).
- On grant: latch msg and address, update last_grant, drive bus_src.
REQ-015 Transitions from IDLE on grant:
- msg 00 -> WRITEMEM.
- Any other msg -> BROADCAST.
REQ-016 BROADCAST SHALL last exactly 1 cycle, with bus_in = {1'b1, msg, address}; bus_in SHALL be 0 in all other states.
REQ-017 Transitions from BROADCAST:
- msg 11 -> RESPOND.
- msg 01 or 10 -> SNOOP.
REQ-018 SNOOP SHALL last 1 cycle and sample cpu_wb, excluding the granted CPU.
- Any flag set: lowest-index flagged CPU wins; memory[address] <= its data; response = that data.
- No flag set: response = memory[address].
REQ-019 WRITEMEM SHALL last 1 cycle, write memory[address] <= granted CPU's cpu_wb_data, set response = 0, then go to RESPOND.
REQ-020 RESPOND SHALL last 1 cycle.
- fill_valid = one-hot(bus_src); fill_data = response (0 for invalidate).
- Next state IDLE.
- fill_valid SHALL be 0 in all other states.
REQ-021 Latency from the granting edge to fill_valid:
- Read/write miss: 3 cycles.
- Invalidate: 2 cycles.
- Write-back: 2 cycles.
REQ-022 Requesters hold valid until fill_valid and drop it at the edge ending RESPOND; the block SHALL NOT re-grant within the same transaction.
REQ-023 Requests arriving while busy SHALL wait and SHALL NOT alter the latched msg or address.
REQ-024 A snoop write-back to the same address in SNOOP SHALL update memory before the next transaction can read it.

Reset
REQ-025 resetn low SHALL immediately force:
- FSM = IDLE; last_grant = 2 (so CPU0 has first priority).
- bus_in, bus_src, fill_data, fill_valid, busy = 0.
- Memory = reset contents per REQ-012.
REQ-026 Reset mid-transaction SHALL abort the transaction with no memory write and no fill_valid pulse.
REQ-027 The first IDLE evaluation SHALL occur at the first rising edge after resetn deasserts.

Verification
REQ-028 Read miss with no write-back:
- Stimulus: CPU1 requests {1,01,101} after reset.
- Response: grant bus_src=1; next cycle bus_in=6'b101101; fill_valid=3'b010 with fill_data=4'h5 three cycles after grant.
REQ-029 Snoop write-back:
- Stimulus: CPU0 write miss at address 3; CPU2 asserts cpu_wb with data 4'hA during SNOOP.
- Response: fill_data=4'hA to CPU0; a later CPU1 read miss at address 3 returns 4'hA.
REQ-030 Round-robin:
- Stimulus: all three CPUs request continuously after reset.
- Response: grants in order 0,1,2,0; each CPU's request is cleared on its own fill_valid.
REQ-031 Invalidate and eviction write-back:
- Invalidate from CPU2: fill_valid=3'b100 and fill_data=0 two cycles after grant; bus_in valid for exactly 1 cycle.
- CPU1 write-back of 4'h9 to address 6: no bus_in broadcast; memory[6]=4'h9.
REQ-032 Reset mid-operation:
- Stimulus: resetn pulsed low during SNOOP of a write miss while a write-back is offered.
- Response: all outputs 0 immediately; no fill_valid; memory unchanged; CPU0 wins the next arbitration.
